// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and transmit FSM states, used by
// both the result transmitter and the instruction-loading receiver.
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int WORD_BYTES           = 2;
  localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/tx_word_fifo.sv
// Show-ahead synchronous word FIFO with push/pop/flush; full and empty are
// decoded from the registered occupancy count.
module tx_word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count need a
  // defined value, and leaving the array unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_result_tx.sv
// Result-word UART transmitter: buffers 16-bit words and sends each as two
// bytes, high byte first. Define UART_TX_PARITY_EN to add an even parity bit.
module uart_result_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   word_data,
  input  logic                          word_valid,
  output logic                          word_ready,
  input  logic                          flush,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int WORD_W = UART_DATA_BITS * WORD_BYTES;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(UART_DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

  tx_state_t                 state_q, state_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic                      half_q, half_d;
  logic [WORD_W-1:0]         holder_q, holder_d;
  logic                      tx_q, tx_d;

  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [WORD_W-1:0]         fifo_dout;
  logic [UART_DATA_BITS-1:0] cur_byte;
  logic                      baud_end;

  tx_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (word_valid),
    .push_data (word_data),
    .pop       (fifo_pop),
    .flush     (flush),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_level)
  );

  assign word_ready = !fifo_full;
  assign busy       = (state_q != TX_IDLE) || !fifo_empty;
  assign tx         = tx_q;
  assign cur_byte   = half_q ? holder_q[7:0] : holder_q[15:8];
  assign baud_end   = (baud_q == BAUD_LAST);

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    half_d   = half_q;
    holder_d = holder_q;
    fifo_pop = 1'b0;
    tx_d     = 1'b1;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          holder_d = fifo_dout;
          half_d   = 1'b0;
          baud_d   = '0;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        tx_d = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        tx_d = cur_byte[bit_q];
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        tx_d = ^cur_byte;
        if (baud_end) begin
          baud_d  = '0;
          state_d = TX_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!half_q) begin
            half_d  = 1'b1;
            state_d = TX_START;
          end else if (!fifo_empty) begin
            // Next word follows the stop bit directly, with no idle gap.
            fifo_pop = 1'b1;
            holder_d = fifo_dout;
            half_d   = 1'b0;
            state_d  = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the combinational block above uses blocking ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= TX_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      half_q   <= 1'b0;
      holder_q <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      half_q   <= half_d;
      holder_q <= holder_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: doc/uart_result_tx.md
# uart_result_tx

Transmit-side UART block for the 16-bit CPU. It accepts 16-bit result words from the CPU core through a valid/ready handshake and buffers them in a small FIFO. Each word is serialized onto the `tx` line as two 8N1 bytes, high byte first. It sits opposite the instruction-loading UART receive path and returns register and memory readback to the host.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, default 8: word FIFO depth. Must be a power of 2, ≥ 2.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset, asynchronous, active-low.
- `word_data`  in  16: result word from the CPU.
- `word_valid`  in  1: `word_data` is valid.
- `word_ready`  out  1: FIFO can accept a word.
- `flush`  in  1: synchronous FIFO clear. A frame already in progress is completed.
- `tx`  out  1: serial line. Idles high.
- `busy`  out  1: FSM is not in IDLE, or the FIFO is not empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: number of words stored.

## Operation
- **Push:** a word is accepted on any edge where `word_valid && word_ready`.
  - `word_ready = !full`, decoded from the registered count.
  - A word offered while full is not accepted. The CPU must hold it.
- **Word sequencing:** per popped word, send byte `word[15:8]`, then byte `word[7:0]`. The word is latched into a 16-bit shift holder when popped.
- **Byte framing:** start bit 0, then 8 data bits LSB first, then stop bit 1.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** `tx`=1. If the FIFO is non-empty, pop, latch the word, set `half`=0, and go to START.
  - **START:** `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with `bit_idx`=0.
  - **DATA:** `tx`=`cur_byte[bit_idx]`. After CLKS_PER_BIT cycles, increment `bit_idx`. After bit 7, go to STOP.
  - **STOP:** `tx`=1 for CLKS_PER_BIT cycles. At the end of the stop bit:
    - if `half`=0: set `half`=1 and go to START (low byte);
    - else if the FIFO is non-empty: pop and go to START (no idle gap);
    - else go to IDLE.
- **Baud counter:** counts 0..CLKS_PER_BIT-1. It is cleared on every state entry and every bit advance.
- **Simultaneous push and pop:** allowed. The count is unchanged. When the FIFO is full, the push is blocked even if a pop happens on the same edge.
- **`flush`:** clears the FIFO pointers and count next edge and takes priority over a same-cycle push. The word already latched into the holder (both bytes) is still fully sent.
- **Pointer wrap:** read and write pointers wrap modulo FIFO_DEPTH. Full/empty are derived from the count.
- **Reset (any time, including mid-frame):** `tx`=1 immediately, FSM=IDLE, FIFO empty, `word_ready`=1 once reset is released.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `word_ready`=1, `fifo_level`=0.
- `tx` is a registered output.
- **Latency from idle:** word accepted at edge N → FIFO non-empty after N → pop at edge N+1 → `tx` falls at edge N+2.
- **Frame lengths:** one byte = 10·CLKS_PER_BIT cycles. One word = 20·CLKS_PER_BIT cycles.
- **Back-to-back words:** the stop bit of one word's low byte is followed directly by the next start bit.
- **`fifo_level`:** updates the edge after a push or pop.
- **`busy`:** rises the edge after the first push and falls when the final stop bit completes with the FIFO empty.

## Configuration
- Macro `UART_TX_PARITY_EN`:
  - **Defined:** a PARITY state is inserted between DATA and STOP. It sends even parity (XOR of the 8 data bits) for one bit period. Byte = 11·CLKS_PER_BIT cycles.
  - **Undefined:** pure 8N1 as above.
- The matching receiver must be built with the same setting.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (`TX_IDLE`, `TX_START`, `TX_DATA`, `TX_PARITY`, `TX_STOP`);
  - `UART_DATA_BITS`=8;
  - `WORD_BYTES`=2;
  - the default CLKS_PER_BIT constant, shared with the receiver.
- Sub-module `tx_word_fifo`: show-ahead synchronous FIFO, 16-bit wide, FIFO_DEPTH entries, with push/pop/flush, full/empty/count.
- Top level holds the FSM, baud counter, bit index, half flag and shift holder.

## Test plan
All scenarios use CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Push 0xA55A from idle → `tx` falls 2 cycles after acceptance. Byte 0xA5 bits are 1,0,1,0,0,1,0,1, then byte 0x5A. Exactly 80 cycles from start edge to line idle. `busy` then drops.
- Push 5 words back-to-back with `word_valid` held high → first 4 accepted in consecutive cycles (the 5th only after the first pop). `word_ready`=0 at `fifo_level`=4. All 10 bytes are sent in order with no idle gaps.
- Push while full on the same cycle as the FSM pop → push refused, `fifo_level` goes 4→3.
- Assert `flush` during the DATA state of a word's high byte with 3 words queued → the current word's two bytes complete, then the line stays idle and `fifo_level`=0.
- Assert `reset` low mid-DATA → `tx`=1 asynchronously. After release: `busy`=0, `word_ready`=1, `fifo_level`=0.
- With `UART_TX_PARITY_EN` defined, push 0x0701 → parity bits 1 (for 0x07) and 1 (for 0x01). Each byte frame is 44 cycles.
